uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  UART transmitter that sits directly downstream of UART_CLOCK and consumes its CLK_TX baud signal.
//  Bytes written by the host are buffered in a small FIFO and serialised on TXD as frames.
//  Frame order: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
//  Every bit lasts exactly one CLK_TX period.
// PARAMETERS
//  DATA_W     8   data bits per frame (5..8)
//  PARITY     0   0 = none, 1 = even, 2 = odd
//  STOP_BITS  1   number of stop bits (1 or 2)
//  FIFO_AW    2   FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  CLK     in   1       system clock; all logic rising-edge
//  RST     in   1       asynchronous reset, active-low (0 = reset)
//  CLK_TX  in   1       baud signal from UART_CLOCK (square wave or pulse), synchronous to CLK
//  DIN     in   DATA_W  byte to transmit
//  WR      in   1       write strobe; DIN is captured when WR=1 and FULL=0
//  FULL    out  1       FIFO holds 2**FIFO_AW entries
//  EMPTY   out  1       FIFO holds 0 entries
//  BUSY    out  1       a frame is in progress (state != IDLE)
//  TXD     out  1       serial line, idle high
// BEHAVIOUR
//  Reset (RST=0, async): TXD=1, BUSY=0, EMPTY=1, FULL=0.
//   FIFO pointers and count are cleared; state=IDLE; the edge-detect register is cleared.
//   Reset mid-frame aborts the frame immediately; TXD goes high with no glitch low.
//  Bit-timing tick: tick = CLK_TX & ~clk_tx_q (registered rising-edge detect), one CLK cycle wide.
//   A tick therefore occurs once per CLK_TX period, whether CLK_TX is a square wave or a pulse.
//  FIFO:
//   - Write when WR & ~FULL; a write while FULL is dropped silently.
//   - A write in the same cycle as a pop is dropped if FULL was 1 in that cycle.
//   - Pop and write in the same cycle when neither FULL nor EMPTY: count is unchanged.
//   - FULL and EMPTY are registered from the count and are valid the cycle after the update.
//   - Pointers wrap modulo 2**FIFO_AW.
//  FSM states: IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE/START.
//   - Every state transition and every TXD change happens only on a tick cycle.
//   - TXD is registered, so it changes one CLK after the tick cycle.
//  IDLE: TXD=1.
//   On a tick with EMPTY=0: pop the head into shift register sr, go to START, drive TXD=0.
//   Data written between ticks waits for the next tick; start-bit latency is at most one baud period + 1 CLK.
//  START: on tick, drive TXD=sr[0], bit counter=0, go to DATA.
//  DATA: on each tick, shift sr right and increment the counter.
//   After bit DATA_W-1 has been held one period: go to PAR if PARITY!=0, else to STOP.
//  PAR: TXD = ^data for even parity, ~^data for odd parity. Parity is computed on the popped byte.
//  STOP: TXD=1 for STOP_BITS periods. At the final stop-period tick:
//   - if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap);
//   - else go to IDLE.
//  BUSY=1 in every state except IDLE.
//  Frame length is 1 + DATA_W + (PARITY!=0) + STOP_BITS periods.
//  Bits of DIN above DATA_W are ignored (DIN width equals DATA_W).
// TESTING
//  1. Reset: hold RST=0 with WR pulsed -> TXD=1, EMPTY=1, FULL=0, BUSY=0. Release; no frame starts.
//  2. Single frame, defaults: write 8'hA5, CLK_TX period 16 CLK.
//     -> TXD reads 0,1,0,1,0,0,1,0,1,1, 16 CLK each, and BUSY drops after the stop bit.
//  3. Parity: PARITY=1 sends 8'h07 with parity bit 1. PARITY=2 sends 8'h07 with parity bit 0.
//     STOP_BITS=2 gives a stop level held 2 periods.
//  4. FIFO full and back-to-back: write 8'h01..8'h05 in 5 consecutive cycles while idle (depth 4).
//     -> FULL=1 after the 4th write. The 5th write is dropped unless a pop occurred first.
//     -> Frames 01,02,03,04 are sent with no idle gap between stop and start. EMPTY=1 after the last pop.
//  5. Reset mid-frame: assert RST=0 during data bit 3 of 8'h00.
//     -> TXD=1 asynchronously and the FIFO is empty. After release the line stays idle.
//  6. Tick sourcing: drive CLK_TX as a 1-cycle pulse, then as a 50% square wave.
//     -> identical bit timing, one bit per CLK_TX period.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter fed by a small FIFO. The host writes bytes into the FIFO,
// and the transmitter sends each one on TXD as a serial frame. A frame is a
// start bit, the data bits LSB first, an optional parity bit, and one or two
// stop bits. Each bit lasts exactly one period of the CLK_TX baud signal.
//
// Parameters
//   DATA_W     data bits per frame (5..8)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//   FIFO_AW    FIFO address width; depth = 2**FIFO_AW
//
// Ports
//   CLK     in   system clock; all logic is rising-edge
//   RST     in   asynchronous reset, active-low
//   CLK_TX  in   baud signal (square wave or pulse), synchronous to CLK
//   DIN     in   data word to queue
//   WR      in   write strobe; DIN is accepted when WR=1 and FULL=0
//   FULL    out  FIFO holds 2**FIFO_AW entries (registered)
//   EMPTY   out  FIFO holds no entries (registered)
//   BUSY    out  a frame is in progress
//   TXD     out  serial line, idles high (registered)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_TX,
  input  logic [DATA_W-1:0] DIN,
  input  logic              WR,
  output logic              FULL,
  output logic              EMPTY,
  output logic              BUSY,
  output logic              TXD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   BIT_ONE   = CNT_W'(1);
  localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Baud tick: one CLK-wide pulse on each rising edge of CLK_TX, so a square
  // wave and a one-cycle pulse produce the same bit timing.
  // ---------------------------------------------------------------------------
  logic clk_tx_q;
  logic tick;

  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples the values present before the edge, independent of block order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) clk_tx_q <= 1'b0;
    else      clk_tx_q <= CLK_TX;
  end

  assign tick = CLK_TX & ~clk_tx_q;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_n;
  logic               full_q;
  logic               empty_q;
  logic               wr_en;
  logic               pop;
  logic [DATA_W-1:0]  head;

  // A write arriving while FULL is dropped, even when a pop frees a slot in
  // the same cycle.
  assign wr_en = WR & ~full_q;
  assign head  = mem[rd_ptr];

  // NOTE: the storage array has no reset. Reset clears the pointers and the
  // count, so stale entries are unreachable and need no clearing.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= DIN;
  end

  always_comb begin
    count_n = count;
    unique case ({wr_en, pop})
      2'b10:   count_n = count + COUNT_ONE;
      2'b01:   count_n = count - COUNT_ONE;
      default: count_n = count;
    endcase
  end

  // The flags are registered from the next count, so they change on the same
  // edge as the count itself.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_n;
      full_q  <= (count_n == DEPTH_C);
      empty_q <= (count_n == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. State and TXD change only on tick cycles. TXD is registered, so
  // the line changes one CLK after the tick.
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_n;
  logic              stop_cnt;
  logic              stop_cnt_n;
  logic              par_bit;
  logic              par_bit_n;
  logic              txd_q;
  logic              txd_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_bit_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block
    // can leave one unassigned and infer a latch.
    state_n    = state;
    sr_n       = sr;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_bit_n  = par_bit;
    txd_n      = txd_q;
    pop        = 1'b0;

    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (!empty_q) pop = 1'b1;
        end
        S_START: begin
          txd_n     = sr[0];
          sr_n      = sr >> 1;
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY != 0) begin
              txd_n   = par_bit;
              state_n = S_PAR;
            end else begin
              txd_n      = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = S_STOP;
            end
          end else begin
            txd_n     = sr[0];
            sr_n      = sr >> 1;
            bit_cnt_n = bit_cnt + BIT_ONE;
          end
        end
        S_PAR: begin
          txd_n      = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = S_STOP;
        end
        S_STOP: begin
          if (stop_cnt == LAST_STOP) begin
            // A queued word starts its frame immediately, with no idle gap.
            if (!empty_q) pop = 1'b1;
            else          state_n = S_IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: begin
          txd_n   = 1'b1;
          state_n = S_IDLE;
        end
      endcase

      // Parity is taken from the word as it leaves the FIFO, before shifting
      // destroys it.
      if (pop) begin
        sr_n      = head;
        par_bit_n = (PARITY == 2) ? ~^head : ^head;
        txd_n     = 1'b0;
        state_n   = S_START;
      end
    end
  end

  assign TXD   = txd_q;
  assign BUSY  = (state != S_IDLE);
  assign FULL  = full_q;
  assign EMPTY = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Three transmitters share the stimulus: (no parity, 1 stop), (even parity,
// 2 stops) and (odd parity, 1 stop). A frame-level reference model predicts
// TXD/BUSY/FULL/EMPTY of each instance. The model treats each frame as a list
// of line levels that advances on every baud tick. The model is compared on
// every falling CLK edge. Literal expectations pin down frame contents,
// parity, frame lengths and reset behaviour.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int N = 3;

  logic       CLK    = 1'b0;
  logic       RST    = 1'b1;
  logic       CLK_TX = 1'b0;
  logic       WR     = 1'b0;
  logic [7:0] DIN    = 8'h00;
  logic [N-1:0] txd, busy, full, empty;

  uart_tx_fifo #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) dut0 (
    .CLK(CLK), .RST(RST), .CLK_TX(CLK_TX), .DIN(DIN), .WR(WR),
    .FULL(full[0]), .EMPTY(empty[0]), .BUSY(busy[0]), .TXD(txd[0]));
  uart_tx_fifo #(.DATA_W(8), .PARITY(1), .STOP_BITS(2), .FIFO_AW(2)) dut1 (
    .CLK(CLK), .RST(RST), .CLK_TX(CLK_TX), .DIN(DIN), .WR(WR),
    .FULL(full[1]), .EMPTY(empty[1]), .BUSY(busy[1]), .TXD(txd[1]));
  uart_tx_fifo #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) dut2 (
    .CLK(CLK), .RST(RST), .CLK_TX(CLK_TX), .DIN(DIN), .WR(WR),
    .FULL(full[2]), .EMPTY(empty[2]), .BUSY(busy[2]), .TXD(txd[2]));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Baud generator: 0 = held low, 1 = square wave, 2 = one-cycle pulse,
  // 3 = random level every cycle.
  // ---------------------------------------------------------------------------
  int tx_mode = 1;
  int tx_per  = 16;
  int phase   = 0;

  initial begin
    forever begin
      @(negedge CLK);
      phase = (phase + 1) % tx_per;
      case (tx_mode)
        0:       CLK_TX = 1'b0;
        1:       CLK_TX = (phase < tx_per / 2);
        2:       CLK_TX = (phase == 0);
        default: CLK_TX = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         p_par  [N] = '{0, 1, 2};
  int         p_stop [N] = '{1, 2, 1};
  logic [7:0] mbuf   [N][4];
  int         mhead  [N];
  int         msize  [N];
  int         mpos   [N];
  int         mlen   [N];
  logic       mbusy  [N];
  logic [11:0] mframe [N];
  logic       mprev;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mhead[i]  = 0;
      msize[i]  = 0;
      mpos[i]   = 0;
      mlen[i]   = 0;
      mbusy[i]  = 1'b0;
      mframe[i] = '1;
    end
    mprev = 1'b0;
  endfunction

  // Take the head word and lay out its whole frame as line levels.
  function automatic void model_pop(input int i);
    logic [7:0]  d;
    logic [11:0] fr;
    int          n;
    d        = mbuf[i][mhead[i]];
    mhead[i] = (mhead[i] + 1) % 4;
    msize[i] = msize[i] - 1;
    fr       = '1;
    fr[0]    = 1'b0;
    for (int k = 0; k < 8; k++) fr[1 + k] = d[k];
    n = 9;
    if (p_par[i] != 0) begin
      fr[n] = (p_par[i] == 1) ? ^d : ~^d;
      n++;
    end
    for (int s = 0; s < p_stop[i]; s++) fr[n + s] = 1'b1;
    mframe[i] = fr;
    mlen[i]   = n + p_stop[i];
    mpos[i]   = 0;
    mbusy[i]  = 1'b1;
  endfunction

  function automatic void model_step();
    logic tk;
    bit   full_pre;
    tk    = CLK_TX & ~mprev;
    mprev = CLK_TX;
    for (int i = 0; i < N; i++) begin
      full_pre = (msize[i] == 4);
      if (tk) begin
        if (!mbusy[i]) begin
          if (msize[i] > 0) model_pop(i);
        end else begin
          mpos[i] = mpos[i] + 1;
          if (mpos[i] >= mlen[i]) begin
            if (msize[i] > 0) model_pop(i);
            else begin
              mbusy[i] = 1'b0;
              mpos[i]  = 0;
            end
          end
        end
      end
      if (WR && !full_pre) begin
        mbuf[i][(mhead[i] + msize[i]) % 4] = DIN;
        msize[i] = msize[i] + 1;
      end
    end
  endfunction

  function automatic int exp_txd(input int i);
    return mbusy[i] ? int'(mframe[i][mpos[i]]) : 1;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) model_reset();
      else      model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        for (int i = 0; i < N; i++) begin
          check($sformatf("txd[%0d]", i),   int'(txd[i]),   exp_txd(i));
          check($sformatf("busy[%0d]", i),  int'(busy[i]),  int'(mbusy[i]));
          check($sformatf("full[%0d]", i),  int'(full[i]),  int'(msize[i] == 4));
          check($sformatf("empty[%0d]", i), int'(empty[i]), int'(msize[i] == 0));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    WR  = 1'b1;
    DIN = b;
    @(negedge CLK);
    WR  = 1'b0;
  endtask

  task automatic wait_low(input int idx, input int max);
    int n = 0;
    while (txd[idx] !== 1'b0 && n < max) begin
      @(negedge CLK);
      n++;
    end
    check($sformatf("start_seen[%0d]", idx), int'(txd[idx]), 0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy !== 3'b000 || empty !== 3'b111) && n < max) begin
      @(negedge CLK);
      n++;
    end
    check("drain_busy", int'(busy), 0);
    check("drain_empty", int'(empty), 7);
  endtask

  // Length of the start-bit low run and of the BUSY window of dut0.
  task automatic measure(output int low_len, output int busy_len);
    wait_low(0, 1000);
    low_len  = 0;
    busy_len = 0;
    while (busy[0] && busy_len < 1000) begin
      if (txd[0] == 1'b0 && low_len == busy_len) low_len++;
      busy_len++;
      @(negedge CLK);
    end
  endtask

  int a5_seq  [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int e07_seq [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lo, bl, n, wprob;

    // Reset with a write strobe active.
    #1 RST = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge CLK);
    WR  = 1'b1;
    DIN = 8'h3C;
    repeat (3) @(negedge CLK);
    WR = 1'b0;
    check("rst_txd",   int'(txd),   7);
    check("rst_empty", int'(empty), 7);
    check("rst_full",  int'(full),  0);
    check("rst_busy",  int'(busy),  0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_txd",  int'(txd),  7);

    // Single frame 8'hA5, 16 CLK per bit.
    send_byte(8'hA5);
    wait_low(0, 100);
    repeat (8) @(negedge CLK);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d", k), int'(txd[0]), a5_seq[k]);
      if (k < 9) repeat (16) @(negedge CLK);
    end
    repeat (10) @(negedge CLK);
    check("a5_busy_end", int'(busy[0]), 0);
    wait_idle(2000);

    // Parity and two stop bits with 8'h07.
    send_byte(8'h07);
    wait_low(1, 100);
    repeat (8) @(negedge CLK);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("e07_bit%0d", k), int'(txd[1]), e07_seq[k]);
      if (k == 9)  check("odd_par_bit", int'(txd[2]), 0);
      if (k == 11) begin
        check("stop2_busy",  int'(busy[1]), 1);
        check("odd_end_busy", int'(busy[2]), 0);
      end
      if (k < 11) repeat (16) @(negedge CLK);
    end
    wait_idle(2000);

    // Fill while the baud signal is stopped, then send back to back.
    tx_mode = 0;
    repeat (20) @(negedge CLK);
    for (int v = 1; v <= 5; v++) begin
      @(negedge CLK);
      WR  = 1'b1;
      DIN = 8'(v);
    end
    @(negedge CLK);
    WR = 1'b0;
    check("fill_full",  int'(full),  7);
    check("fill_empty", int'(empty), 0);
    tx_mode = 1;
    tx_per  = 16;
    n = 0;
    while (!busy[0] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    bl = 0;
    while (busy[0] && bl < 2000) begin
      bl++;
      @(negedge CLK);
    end
    check("b2b_busy_len", bl, 640);
    check("b2b_empty", int'(empty[0]), 1);
    wait_idle(2000);

    // Reset during data bit 3 of 8'h00.
    send_byte(8'h00);
    wait_low(0, 100);
    repeat (16 * 4 + 8) @(negedge CLK);
    check("mid_frame_low", int'(txd[0]), 0);
    #2 RST = 1'b0;
    #1;
    check("abort_txd",   int'(txd),   7);
    check("abort_busy",  int'(busy),  0);
    check("abort_empty", int'(empty), 7);
    check("abort_full",  int'(full),  0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (80) @(negedge CLK);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_txd",  int'(txd),  7);

    // Pulse and square-wave baud give identical bit timing.
    tx_mode = 2;
    tx_per  = 12;
    send_byte(8'h01);
    measure(lo, bl);
    check("pulse_start_len", lo, 12);
    check("pulse_frame_len", bl, 120);
    wait_idle(2000);
    tx_mode = 1;
    send_byte(8'h01);
    measure(lo, bl);
    check("square_start_len", lo, 12);
    check("square_frame_len", bl, 120);
    wait_idle(2000);

    // Random traffic with varying baud style and rate.
    for (int seg = 0; seg < 6; seg++) begin
      tx_mode = $urandom_range(1, 3);
      tx_per  = $urandom_range(3, 20);
      wprob   = $urandom_range(2, 40);
      repeat (500) begin
        @(negedge CLK);
        WR  = ($urandom_range(0, wprob - 1) == 0);
        DIN = 8'($urandom);
      end
    end
    @(negedge CLK);
    WR = 1'b0;
    tx_mode = 1;
    tx_per  = 8;
    wait_idle(5000);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
